// File: rtl/reg_file_pkg.sv
// reg_file_pkg: shared defaults and sizing helpers for the scoreboarded register file.
package reg_file_pkg;
  localparam int DATA_W_DEF  = 32;
  localparam int ADDR_W_DEF  = 4;
  localparam int NUM_RD_DEF  = 2;
  localparam int ZERO_R0_DEF = 0;
  localparam int RD_ADDR_W_DEF = NUM_RD_DEF * ADDR_W_DEF;
  localparam int RD_DATA_W_DEF = NUM_RD_DEF * DATA_W_DEF;
  function automatic int depth_of(input int aw);
    return 1 << aw;
  endfunction
endpackage

// File: rtl/rf_scoreboard.sv
// rf_scoreboard: per-register pending-load bits, ALU write qualification and hazard error pulse.
module rf_scoreboard import reg_file_pkg::*; #(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int ZERO_R0 = ZERO_R0_DEF,
  localparam int DEPTH  = depth_of(ADDR_W)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic              ld_issue,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic              ld_ret_valid,
  input  logic [ADDR_W-1:0] ld_ret_addr,
  output logic [DEPTH-1:0]  busy_vec,
  output logic              wr_ok,
  output logic              err
);
  logic [DEPTH-1:0] busy_q, busy_d;
  logic err_q, err_d, ret_hit_wr, ret_hit_ld;
  function automatic logic is_r0(input logic [ADDR_W-1:0] a);
    return ZERO_R0 != 0 && a == '0;
  endfunction
  always_comb begin
    ret_hit_wr = ld_ret_valid && ld_ret_addr == wr_addr;
    ret_hit_ld = ld_ret_valid && ld_ret_addr == ld_addr;
    wr_ok = wr_en && !busy_q[wr_addr] && !ret_hit_wr && !is_r0(wr_addr);
    err_d = (wr_en && (busy_q[wr_addr] || ret_hit_wr) && !is_r0(wr_addr))
         || (ld_issue && busy_q[ld_addr] && !ret_hit_ld && !is_r0(ld_addr))
         || (ld_ret_valid && !busy_q[ld_ret_addr] && !is_r0(ld_ret_addr));
    busy_d = busy_q;
    // an issue in the same cycle as a return re-arms the bit, so set follows clear
    if (ld_ret_valid) busy_d[ld_ret_addr] = 1'b0;
    if (ld_issue) busy_d[ld_addr] = 1'b1;
    if (ZERO_R0 != 0) busy_d[0] = 1'b0;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy_q <= '0;
      err_q  <= 1'b0;
    end else begin
      busy_q <= busy_d;
      err_q  <= err_d;
    end
  end
  assign busy_vec = busy_q;
  assign err      = err_q;
endmodule

// File: rtl/reg_file_sb.sv
// reg_file_sb: multi-port register file with write bypass and a load scoreboard.
module reg_file_sb import reg_file_pkg::*; #(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int NUM_RD  = NUM_RD_DEF,
  parameter int ZERO_R0 = ZERO_R0_DEF,
  localparam int DEPTH  = depth_of(ADDR_W)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     ld_issue,
  input  logic [ADDR_W-1:0]        ld_addr,
  input  logic                     ld_ret_valid,
  input  logic [ADDR_W-1:0]        ld_ret_addr,
  input  logic [DATA_W-1:0]        ld_ret_data,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  output logic                     stall,
  output logic [DEPTH-1:0]         busy_vec,
  output logic [DEPTH*DATA_W-1:0]  regs_flat,
  output logic                     err
);
  logic [DATA_W-1:0] regs_q [DEPTH];
  logic [DATA_W-1:0] regs_d [DEPTH];
  logic wr_ok;
  rf_scoreboard #(.ADDR_W(ADDR_W), .ZERO_R0(ZERO_R0)) u_sb (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr),
    .ld_issue(ld_issue), .ld_addr(ld_addr), .ld_ret_valid(ld_ret_valid),
    .ld_ret_addr(ld_ret_addr), .busy_vec(busy_vec), .wr_ok(wr_ok), .err(err)
  );
  always_comb begin
    regs_d = regs_q;
    if (ld_ret_valid) regs_d[ld_ret_addr] = ld_ret_data;
    if (wr_ok) regs_d[wr_addr] = wr_data;
    if (ZERO_R0 != 0) regs_d[0] = '0;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) regs_q <= '{default: '0};
    else regs_q <= regs_d;
  end
  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] a;
    logic ret_hit;
    assign a       = rd_addr[k*ADDR_W +: ADDR_W];
    assign ret_hit = ld_ret_valid && ld_ret_addr == a;
    assign rd_data[k*DATA_W +: DATA_W] = (ZERO_R0 != 0 && a == '0) ? '0
                                       : ret_hit ? ld_ret_data
                                       : (wr_ok && wr_addr == a) ? wr_data : regs_q[a];
    assign rd_busy[k] = busy_vec[a] && !ret_hit;
  end
  for (genvar i = 0; i < DEPTH; i++) begin : g_flat
    assign regs_flat[i*DATA_W +: DATA_W] = regs_q[i];
  end
  assign stall = |rd_busy;
endmodule

// File: tb/tb_reg_file_sb.sv
// tb_reg_file_sb: directed checks of reg_file_sb, default build plus a ZERO_R0 build on shared stimulus.
module tb_reg_file_sb;
  logic clk = 0, rst_n = 0;
  logic wr_en = 0, ld_issue = 0, ld_ret_valid = 0;
  logic [3:0] wr_addr = 0, ld_addr = 0, ld_ret_addr = 0;
  logic [31:0] wr_data = 0, ld_ret_data = 0;
  logic [7:0] rd_addr = 0;
  logic [63:0] rd_data, rd_data_z;
  logic [1:0] rd_busy, rd_busy_z;
  logic stall, stall_z, err, err_z;
  logic [15:0] busy_vec, busy_z;
  logic [511:0] regs_flat, flat_z;
  int n_chk = 0, n_fail = 0;

  always #5 clk = ~clk;

  reg_file_sb dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .ld_issue(ld_issue), .ld_addr(ld_addr), .ld_ret_valid(ld_ret_valid),
    .ld_ret_addr(ld_ret_addr), .ld_ret_data(ld_ret_data), .rd_addr(rd_addr),
    .rd_data(rd_data), .rd_busy(rd_busy), .stall(stall), .busy_vec(busy_vec),
    .regs_flat(regs_flat), .err(err)
  );
  reg_file_sb #(.ZERO_R0(1)) dut_z (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .ld_issue(ld_issue), .ld_addr(ld_addr), .ld_ret_valid(ld_ret_valid),
    .ld_ret_addr(ld_ret_addr), .ld_ret_data(ld_ret_data), .rd_addr(rd_addr),
    .rd_data(rd_data_z), .rd_busy(rd_busy_z), .stall(stall_z), .busy_vec(busy_z),
    .regs_flat(flat_z), .err(err_z)
  );

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] reg_of(input logic [511:0] f, input int i);
    return f[i*32 +: 32];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr_en = 0; ld_issue = 0; ld_ret_valid = 0;
  endtask

  initial begin
    tick();
    tick();
    rst_n = 1;
    #1;
    chk("reset rd_data", rd_data, 0);
    chk("reset rd_busy", rd_busy, 0);
    chk("reset stall", stall, 0);
    chk("reset busy_vec", busy_vec, 0);
    chk("reset regs_flat", regs_flat, 0);
    chk("reset err", err, 0);

    wr_en = 1; wr_addr = 3; wr_data = 32'hAA; rd_addr = 8'h03;
    #1 chk("wr bypass r3", rd_data[31:0], 32'hAA);
    tick(); idle();
    chk("rd r3", rd_data[31:0], 32'hAA);
    chk("rd_busy0 r3", rd_busy[0], 0);
    chk("err after wr", err, 0);

    ld_issue = 1; ld_addr = 5;
    tick(); idle();
    rd_addr = 8'h53;
    #1;
    chk("rd_busy pending r5", rd_busy, 2'b10);
    chk("stall pending r5", stall, 1);
    chk("busy_vec[5] set", busy_vec[5], 1);
    ld_ret_valid = 1; ld_ret_addr = 5; ld_ret_data = 32'h1234;
    #1;
    chk("ret bypass r5", rd_data[63:32], 32'h1234);
    chk("rd_busy1 on ret", rd_busy[1], 0);
    chk("stall on ret", stall, 0);
    tick(); idle();
    chk("busy_vec after ret", busy_vec, 0);
    chk("r5 after ret", reg_of(regs_flat, 5), 32'h1234);
    chk("err after ret", err, 0);

    ld_issue = 1; ld_addr = 7;
    tick(); idle();
    wr_en = 1; wr_addr = 7; wr_data = 32'h55; rd_addr = 8'h07;
    #1 chk("no bypass of WAW", rd_data[31:0], 0);
    tick(); idle();
    chk("r7 unchanged WAW", reg_of(regs_flat, 7), 0);
    chk("err WAW", err, 1);
    tick();
    chk("err WAW one cycle", err, 0);

    wr_en = 1; wr_addr = 2; wr_data = 32'h11;
    ld_ret_valid = 1; ld_ret_addr = 2; ld_ret_data = 32'h22; rd_addr = 8'h02;
    #1 chk("bypass ret priority", rd_data[31:0], 32'h22);
    tick(); idle();
    chk("r2 ret wins", reg_of(regs_flat, 2), 32'h22);
    chk("err collision", err, 1);
    tick();
    chk("err collision one cycle", err, 0);

    ld_issue = 1; ld_addr = 4;
    tick(); idle();
    tick();
    tick();
    ld_ret_valid = 1; ld_ret_addr = 4; ld_ret_data = 32'h9; ld_issue = 1; ld_addr = 4;
    tick(); idle();
    chk("r4 ret+issue data", reg_of(regs_flat, 4), 32'h9);
    chk("busy_vec[4] re-armed", busy_vec[4], 1);
    chk("err ret+issue", err, 0);

    ld_issue = 1; ld_addr = 4;
    tick(); idle();
    chk("err double issue", err, 1);
    chk("busy_vec[4] kept", busy_vec[4], 1);

    wr_en = 1; wr_addr = 1; wr_data = 32'h77;
    ld_ret_valid = 1; ld_ret_addr = 4; ld_ret_data = 32'h44;
    ld_issue = 1; ld_addr = 6;
    tick(); idle();
    chk("indep r1", reg_of(regs_flat, 1), 32'h77);
    chk("indep r4", reg_of(regs_flat, 4), 32'h44);
    chk("indep busy_vec", busy_vec, 16'h00C0);
    chk("indep err", err, 0);

    ld_ret_valid = 1; ld_ret_addr = 9; ld_ret_data = 32'hBEEF;
    tick(); idle();
    chk("r9 stray ret data", reg_of(regs_flat, 9), 32'hBEEF);
    chk("err stray ret", err, 1);

    wr_en = 1; wr_addr = 0; wr_data = 32'hDEAD; ld_issue = 1; ld_addr = 0;
    tick(); idle();
    rd_addr = 8'h00;
    #1;
    chk("r0 stored (ZERO_R0=0)", reg_of(regs_flat, 0), 32'hDEAD);
    chk("r0 busy (ZERO_R0=0)", busy_vec[0], 1);
    chk("z r0 reads 0", rd_data_z[31:0], 0);
    chk("z r0 flat 0", reg_of(flat_z, 0), 0);
    chk("z r0 never busy", busy_z[0], 0);
    chk("z rd_busy0", rd_busy_z[0], 0);
    chk("z no err", err_z, 0);
    wr_en = 1; wr_addr = 0; wr_data = 32'h1;
    #1 chk("z r0 no bypass", rd_data_z[31:0], 0);
    tick(); idle();
    chk("err write busy r0", err, 1);
    chk("z no err on r0", err_z, 0);

    for (int i = 1; i < 16; i++) begin
      wr_en = 1; wr_addr = 4'(i); wr_data = 32'(i) * 32'h101;
      tick();
    end
    idle();
    chk("r15 before reset", reg_of(regs_flat, 15), 32'h0F0F);
    rst_n = 0; wr_en = 1; wr_addr = 1; wr_data = 32'h5; ld_issue = 1; ld_addr = 9;
    tick(); idle();
    rst_n = 1;
    #1;
    chk("post-reset regs_flat", regs_flat, 0);
    chk("post-reset busy_vec", busy_vec, 0);
    chk("post-reset err", err, 0);
    chk("post-reset rd_data", rd_data, 0);
    chk("post-reset stall", stall, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
